// File: rtl/pipe_ctrl_n_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_n_pkg
//   Shared definitions for the pipeline control unit: default stall bus
//   width, the control FSM state encoding and the pipeline stage indices.
//   No ports (package).
// ---------------------------------------------------------------------------
package pipe_ctrl_n_pkg;

    // Default number of pipeline stages (PC/IF .. WB).
    localparam int unsigned NSTAGE_DEF = 6;

    // One bit per stage; bit 0 is the front of the pipe.
    typedef logic [NSTAGE_DEF-1:0] stall_bus_t;

    // Control FSM: normal operation or the single-cycle flush/redirect.
    typedef enum logic [0:0] {
        CTRL_IDLE  = 1'b0,
        CTRL_FLUSH = 1'b1
    } ctrl_state_e;

    // Stage index constants for the default six-stage core.
    localparam int unsigned ST_PC  = 0;
    localparam int unsigned ST_IF  = 1;
    localparam int unsigned ST_ID  = 2;
    localparam int unsigned ST_EX  = 3;
    localparam int unsigned ST_MEM = 4;
    localparam int unsigned ST_WB  = 5;

endpackage

// File: rtl/pipe_ctrl_n_wdog.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_n_wdog
//   Consecutive-stall watchdog. Counts cycles in which the front of the pipe
//   is frozen while the controller is idle; saturates at all-ones and clears
//   on any cycle that is not counted. A sticky timeout flag rises on the
//   edge where the count reaches LIMIT and only reset clears it.
// Ports
//   clk      in   1        clock
//   rst      in   1        asynchronous, active-low reset
//   inc      in   1        this cycle counts as a stalled cycle
//   count    out  WDOG_W   current consecutive-stall count
//   timeout  out  1        sticky watchdog flag
// ---------------------------------------------------------------------------
module pipe_ctrl_n_wdog #(
    parameter int unsigned        WDOG_W = 16,
    parameter logic [WDOG_W-1:0]  LIMIT  = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [WDOG_W-1:0] count,
    output logic              timeout
);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_nxt;
    logic              timeout_q;

    always_comb begin
        cnt_nxt = '0;
        if (inc) begin
            cnt_nxt = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // The flag is set on the same edge the counter lands on LIMIT, so it is
    // visible right after the LIMIT-th stalled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            if (inc && (cnt_nxt == LIMIT)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign count   = cnt_q;
    assign timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl_n.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_n
//   Pipeline control unit for the N-stage core. Turns per-stage stall
//   requests into a thermometer stall vector plus bubble markers, sequences
//   a one-cycle whole-pipe flush with a registered redirect PC, and runs a
//   consecutive-stall watchdog.
// Ports
//   clk            in   1         core clock
//   rst            in   1         asynchronous, active-low reset
//   stall_req      in   NSTAGE    bit k: stage k freezes stages 0..k
//   flush_req      in   1         exception/eret flush request
//   flush_pc       in   PC_W      redirect target, sampled with flush_req
//   stall          out  NSTAGE    stage holds its register
//   bubble         out  NSTAGE    stage loads a NOP
//   flush          out  NSTAGE    stage clears its register
//   new_pc_valid   out  1         IF must load new_pc this cycle
//   new_pc         out  PC_W      redirect PC
//   wdog_timeout   out  1         sticky stall watchdog flag
//   dbg_state      out  1         control FSM state (0 idle, 1 flush)
//   perf_stall_cyc out  32        cycles with stall[0] set   (PIPE_CTRL_PERF_EN)
//   perf_flush_cnt out  32        flush cycles               (PIPE_CTRL_PERF_EN)
// Configuration
//   PIPE_CTRL_PERF_EN : adds the two wrapping performance counters.
// Handshake
//   No valid/ready pairs: stall/bubble are level outputs valid in the cycle
//   they are driven; new_pc is meaningful only while new_pc_valid is high.
// ---------------------------------------------------------------------------
module pipe_ctrl_n
    import pipe_ctrl_n_pkg::*;
#(
    parameter int unsigned        NSTAGE     = NSTAGE_DEF,
    parameter int unsigned        PC_W       = 32,
    parameter int unsigned        WDOG_W     = 16,
    parameter logic [WDOG_W-1:0]  WDOG_LIMIT = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              flush_req,
    input  logic [PC_W-1:0]   flush_pc,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] bubble,
    output logic [NSTAGE-1:0] flush,
    output logic              new_pc_valid,
    output logic [PC_W-1:0]   new_pc,
    output logic              wdog_timeout,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_flush_cnt,
`endif
    output logic              dbg_state
);

    ctrl_state_e       state_q, state_d;
    logic [PC_W-1:0]   new_pc_q, new_pc_d;
    logic [NSTAGE-1:0] stall_therm;
    logic [NSTAGE-1:0] stall_v;
    logic [NSTAGE-1:0] bubble_v;
    logic [WDOG_W-1:0] wdog_count;
    logic              wdog_inc;

    // Thermometer: stage i is frozen if any stage at or downstream of i asks.
    always_comb begin
        stall_therm = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            stall_therm[i] = |(stall_req >> i);
        end
    end

    // A flush overrides every stall; bubbles mark the first un-stalled stage
    // behind a frozen one.
    always_comb begin
        stall_v  = (state_q == CTRL_FLUSH) ? '0 : stall_therm;
        bubble_v = '0;
        for (int i = 1; i < NSTAGE; i++) begin
            bubble_v[i] = stall_v[i-1] & ~stall_v[i];
        end
    end

    // Control FSM, next state and redirect capture.
    always_comb begin
        state_d  = state_q;
        new_pc_d = new_pc_q;
        case (state_q)
            CTRL_IDLE: begin
                if (flush_req) begin
                    state_d  = CTRL_FLUSH;
                    new_pc_d = flush_pc;
                end
            end
            CTRL_FLUSH: begin
                if (flush_req) begin
                    state_d  = CTRL_FLUSH;
                    new_pc_d = flush_pc;
                end else begin
                    state_d  = CTRL_IDLE;
                end
            end
            default: begin
                state_d = CTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CTRL_IDLE;
            new_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            new_pc_q <= new_pc_d;
        end
    end

    // Flush outputs decode straight from the state register so an
    // asynchronous reset removes them without waiting for a clock edge.
    assign flush        = (state_q == CTRL_FLUSH) ? '1 : '0;
    assign new_pc_valid = (state_q == CTRL_FLUSH);
    assign new_pc       = new_pc_q;
    assign stall        = stall_v;
    assign bubble       = bubble_v;
    assign dbg_state    = state_q;

    // FLUSH cycles force stall[0] low, so this also clears the count there.
    assign wdog_inc = (state_q == CTRL_IDLE) & stall_therm[0];

    pipe_ctrl_n_wdog #(
        .WDOG_W (WDOG_W),
        .LIMIT  (WDOG_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .inc     (wdog_inc),
        .count   (wdog_count),
        .timeout (wdog_timeout)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_v[0]) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (state_q == CTRL_FLUSH) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

    // The count is kept internal; only the sticky flag leaves the block.
    logic unused_wdog;
    assign unused_wdog = ^wdog_count;

endmodule
